// File: rtl/check_bet.sv
// check_bet: lottery bet checker.
// Each Set strobe checks one bet slot (selected by `number`) against the four
// winning numbers. `hit` counts matches for the bet in progress. Slot 3
// completes the bet and adds its prize to the saturating 10-bit `sum`.
// Optional build macro BET_RANGE_CHECK_EN: a bet value of 0 never matches and
// flags the bet as erroneous, so that bet earns no prize.
module check_bet #(
    parameter int PRIZE2 = 10,
    parameter int PRIZE3 = 100,
    parameter int PRIZE4 = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] W1,
    input  logic [4:0] W2,
    input  logic [4:0] W3,
    input  logic [4:0] W4,
    input  logic [4:0] B1,
    input  logic [4:0] B2,
    input  logic [4:0] B3,
    input  logic [4:0] B4,
    input  logic       Set,
    input  logic       RD_ERR,
    input  logic [1:0] number,
    output logic [2:0] hit,
    output logic [9:0] sum
);

    // Error flag for the bet in progress.
    logic       err;
    // Set once a bet has been started with slot 0. Reset clears it, so a bet
    // interrupted by reset cannot pay out from its leftover slots.
    logic       live;

    logic [4:0] sel;
    logic       match;
    logic       bad;
    logic [2:0] hit_base;
    logic [2:0] hit_nxt;
    logic       err_nxt;
    logic       live_nxt;
    logic [9:0] prize;
    logic [10:0] sum_add;
    logic [9:0] sum_nxt;

    // Select the bet value for the slot being checked.
    always_comb begin
        sel = B1;
        case (number)
            2'd0: sel = B1;
            2'd1: sel = B2;
            2'd2: sel = B3;
            2'd3: sel = B4;
            default: sel = B1;
        endcase
    end

    // Match against any winning number; duplicates in W still give one hit.
    always_comb begin
        bad   = 1'b0;
        match = (sel == W1) | (sel == W2) | (sel == W3) | (sel == W4);
`ifdef BET_RANGE_CHECK_EN
        if (sel == 5'd0) begin
            bad   = 1'b1;
            match = 1'b0;
        end
`endif
    end

    // Next hit count, error flag, and the prize for a completing slot.
    always_comb begin
        hit_base = (number == 2'd0) ? 3'd0 : hit;
        hit_nxt  = (hit_base >= 3'd4) ? 3'd4 : hit_base + {2'b00, match};
        err_nxt  = ((number == 2'd0) ? 1'b0 : err) | RD_ERR | bad;
        live_nxt = (number == 2'd0) ? 1'b1 : live;

        prize = 10'd0;
        if (!err_nxt && live_nxt) begin
            case (hit_nxt)
                3'd2:    prize = 10'(PRIZE2);
                3'd3:    prize = 10'(PRIZE3);
                3'd4:    prize = 10'(PRIZE4);
                default: prize = 10'd0;
            endcase
        end

        sum_add = {1'b0, sum} + {1'b0, prize};
        sum_nxt = sum_add[10] ? 10'd1023 : sum_add[9:0];
    end

    // Bet state register; updates only on a Set cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit  <= 3'd0;
            sum  <= 10'd0;
            err  <= 1'b0;
            live <= 1'b0;
        end else if (Set) begin
            hit  <= hit_nxt;
            err  <= err_nxt;
            live <= live_nxt;
            if (number == 2'd3)
                sum <= sum_nxt;
        end
    end

endmodule

// File: tb/tb_check_bet.sv
// Self-checking bench for check_bet: a reference model pushes expected
// {hit,sum} into a scoreboard as each Set is driven; the entry is popped and
// compared after the clock edge.
module tb_check_bet;

    logic       clk;
    logic       reset;
    logic [4:0] W1, W2, W3, W4;
    logic [4:0] B1, B2, B3, B4;
    logic       Set;
    logic       RD_ERR;
    logic [1:0] number;
    logic [2:0] hit;
    logic [9:0] sum;

    int tests;
    int fails;

    // reference model state
    int mh;
    int ms;
    bit me;
    bit ml;

    logic [12:0] sbq[$];

    check_bet dut (
        .clk(clk), .reset(reset),
        .W1(W1), .W2(W2), .W3(W3), .W4(W4),
        .B1(B1), .B2(B2), .B3(B3), .B4(B4),
        .Set(Set), .RD_ERR(RD_ERR), .number(number),
        .hit(hit), .sum(sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        W1 = 5'(a); W2 = 5'(b); W3 = 5'(c); W4 = 5'(d);
    endtask

    task automatic set_bet(input int a, input int b, input int c, input int d);
        B1 = 5'(a); B2 = 5'(b); B3 = 5'(c); B4 = 5'(d);
    endtask

    // One Set cycle on slot n with read error e.
    task automatic do_set(input int n, input bit e, input string tag);
        int v;
        int m;
        int p;
        logic [12:0] x;
        @(negedge clk);
        number = 2'(n);
        RD_ERR = e;
        Set    = 1'b1;
        v = (n == 0) ? int'(B1) : (n == 1) ? int'(B2) : (n == 2) ? int'(B3) : int'(B4);
        m = (v == int'(W1) || v == int'(W2) || v == int'(W3) || v == int'(W4)) ? 1 : 0;
        if (n == 0) begin
            mh = m; me = e; ml = 1'b1;
        end else begin
            mh = (mh + m > 4) ? 4 : mh + m;
            me = me | e;
        end
        if (n == 3 && !me && ml) begin
            p = (mh == 2) ? 10 : (mh == 3) ? 100 : (mh == 4) ? 500 : 0;
            ms = (ms + p > 1023) ? 1023 : ms + p;
        end
        sbq.push_back({3'(mh), 10'(ms)});
        @(posedge clk);
        #1;
        Set    = 1'b0;
        RD_ERR = 1'b0;
        x = sbq.pop_front();
        chk({tag, "_hit"}, int'(hit), int'(x[12:10]));
        chk({tag, "_sum"}, int'(sum), int'(x[9:0]));
    endtask

    // Full bet: slots 0..3 in order, errm selects slots with RD_ERR.
    task automatic run_bet(input int a, input int b, input int c, input int d,
                           input logic [3:0] errm, input string tag);
        set_bet(a, b, c, d);
        for (int i = 0; i < 4; i++)
            do_set(i, errm[i], $sformatf("%s_s%0d", tag, i));
    endtask

    initial begin
        tests = 0; fails = 0;
        mh = 0; ms = 0; me = 1'b0; ml = 1'b0;
        reset = 1'b0; Set = 1'b0; RD_ERR = 1'b0; number = 2'd0;
        set_w(4, 21, 22, 30);
        set_bet(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit", int'(hit), 0);
        chk("rst_sum", int'(sum), 0);
        @(negedge clk);
        reset = 1'b1;

        run_bet(1, 3, 22, 26, 4'b0000, "b_1hit");
        chk("plan_sum0", int'(sum), 0);
        run_bet(4, 21, 23, 30, 4'b0000, "b_3hit");
        chk("plan_sum100", int'(sum), 100);
        run_bet(21, 22, 23, 24, 4'b0000, "b_2hit");
        chk("plan_sum110", int'(sum), 110);
        run_bet(4, 28, 29, 31, 4'b0000, "b_1hitb");
        chk("plan_sum110b", int'(sum), 110);
        run_bet(4, 21, 22, 30, 4'b0000, "b_4hit");
        chk("plan_sum610", int'(sum), 610);

        // read error on slot 2: hits still counted, no prize
        run_bet(4, 21, 22, 30, 4'b0100, "b_err");
        chk("err_hit4", int'(hit), 4);
        chk("err_sum", int'(sum), 610);

        // idle cycles hold state
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hit", int'(hit), 4);
        chk("idle_sum", int'(sum), 610);

        // next bet pays normally and saturates
        run_bet(4, 21, 22, 30, 4'b0000, "b_sat1");
        chk("sat_sum1023", int'(sum), 1023);
        run_bet(4, 21, 22, 30, 4'b0000, "b_sat2");
        chk("sat_hold", int'(sum), 1023);

        // duplicate winning numbers give one hit per check
        set_w(5, 5, 5, 5);
        run_bet(5, 6, 7, 8, 4'b0000, "b_dupw");
        chk("dupw_hit1", int'(hit), 1);
        set_w(4, 21, 22, 30);

        // asynchronous reset mid-bet
        set_bet(4, 21, 22, 30);
        do_set(0, 1'b0, "ab_s0");
        do_set(1, 1'b0, "ab_s1");
        #2;
        reset = 1'b0;
        mh = 0; ms = 0; me = 1'b0; ml = 1'b0;
        #1;
        chk("arst_hit", int'(hit), 0);
        chk("arst_sum", int'(sum), 0);
        @(negedge clk);
        reset = 1'b1;
        do_set(2, 1'b0, "ab_s2");
        do_set(3, 1'b0, "ab_s3");
        chk("ab_noprize", int'(sum), 0);
        run_bet(4, 21, 22, 30, 4'b0000, "b_after");
        chk("after_sum500", int'(sum), 500);

        // hit saturates at 4 when a slot is repeated
        set_bet(4, 21, 22, 30);
        do_set(0, 1'b0, "rp_s0");
        for (int i = 0; i < 4; i++)
            do_set(1, 1'b0, $sformatf("rp_s1_%0d", i));
        chk("rp_hit4", int'(hit), 4);
        do_set(3, 1'b0, "rp_s3");
        chk("rp_sum1000", int'(sum), 1000);
        run_bet(21, 22, 23, 24, 4'b0000, "b_2hitc");
        chk("sum1010", int'(sum), 1010);
        run_bet(4, 21, 23, 30, 4'b0000, "b_3hitc");
        chk("sum_sat3", int'(sum), 1023);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
